// File: rtl/inst_fetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian words into a prefetch FIFO with valid/ready output.
// First word visible 5 cycles after request start; stops starting words when FIFO plus in-progress word would exceed DEPTH.
module inst_fetch_unit #(
  parameter int          ADDR_W   = 12,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_C = (PW+2)'(DEPTH);
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_WAIT  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic [1:0]    k;
  logic          wip;
  logic          rd_pend;
  logic [1:0]    rd_k;
  logic [23:0]   asm_q;
  logic [31:0]   asm_pc;
  logic [31:0]   fifo_dat [DEPTH];
  logic [31:0]   fifo_pc  [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   cnt;
  logic [31:0]   hold_inst;
  logic [31:0]   hold_pc;
  logic [31:0]   tgt_pc;
  logic [PW+1:0] used;
  logic          pop;
  logic          push;
  logic          can_start;
  logic          issue;

  always_comb begin
    tgt_pc    = redirect_pc & ~32'h3;
    inst_valid = (cnt != '0);
    pop       = inst_valid && inst_ready && !redirect;
    push      = rd_pend && (rd_k == 2'd3) && !redirect;
    // A word being issued or awaiting its last byte holds a slot; a pop this cycle frees one.
    used      = {1'b0, cnt} + {{(PW+1){1'b0}}, wip} - {{(PW+1){1'b0}}, pop};
    can_start = (used < DEPTH_C);
    issue     = rst && !redirect && (state == S_FETCH) && ((k != 2'd0) || can_start);
    mem_req   = issue;
    mem_addr  = rst ? (fetch_pc[ADDR_W-1:0] + ADDR_W'(k)) : '0;
    wr_ptr    = rd_ptr + cnt[PW-1:0];
    inst      = inst_valid ? fifo_dat[rd_ptr] : hold_inst;
    inst_pc   = inst_valid ? fifo_pc[rd_ptr]  : hold_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FETCH;
      fetch_pc  <= RESET_PC;
      k         <= 2'd0;
      wip       <= 1'b0;
      rd_pend   <= 1'b0;
      rd_k      <= 2'd0;
      asm_q     <= '0;
      asm_pc    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      hold_inst <= '0;
      hold_pc   <= '0;
    end else begin
      rd_pend <= issue;
      rd_k    <= k;
      if (inst_valid) begin
        hold_inst <= inst;
        hold_pc   <= inst_pc;
      end
      if (redirect) begin
        state    <= S_FETCH;
        fetch_pc <= tgt_pc;
        k        <= 2'd0;
        wip      <= 1'b0;
        asm_q    <= '0;
        rd_ptr   <= '0;
        cnt      <= '0;
      end else begin
        if (rd_pend)
          asm_q <= {asm_q[15:0], mem_rdata};
        if (issue) begin
          k <= k + 2'd1;
          if (k == 2'd3)
            fetch_pc <= fetch_pc + 32'd4;
          if (k == 2'd0)
            asm_pc <= fetch_pc;
        end
        if (issue && (k == 2'd0))
          wip <= 1'b1;
        else if (push)
          wip <= 1'b0;
        if (state == S_FETCH) begin
          if ((k == 2'd0) && !can_start)
            state <= S_WAIT;
        end else if (can_start) begin
          state <= S_FETCH;
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_dat[wr_ptr] <= {asm_q, mem_rdata};
      fifo_pc[wr_ptr]  <= asm_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a byte memory model and an expected-word scoreboard.
module tb_inst_fetch_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  logic [7:0] imem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_req) mem_rdata <= imem[mem_addr];

  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  logic [63:0] exp_q[$];
  int          acc_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample in the middle of the cycle; record and score every accepted word.
  task automatic smp();
    @(negedge clk);
    if (rst && inst_valid && inst_ready && !redirect) begin
      acc_cyc.push_back(cyc_n);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_extra observed pc=%h inst=%h expected=none", inst_pc, inst);
      end
      if (exp_q.size() != 0) chk("sb_word", {inst_pc, inst}, exp_q.pop_front());
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) imem[(a + b) % (1 << AW)] = w[31-8*b -: 8];
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      smp();
      adv();
      n++;
    end
    inst_ready = 1'b0;
    chk("sb_drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    smp();
    chk("rst_cycle_req", 64'(mem_req), 64'd0);
    adv();
    rst = 1'b1;
    cyc_n = 0;
    acc_cyc.delete();
  endtask

  task automatic redir(input logic [31:0] pc, input logic [31:0] first_pc);
    int t;
    logic [AW-1:0] a;
    acc_cyc.delete();
    t = cyc_n;
    redirect = 1'b1;
    redirect_pc = pc;
    inst_ready = 1'b1;
    smp();
    chk("redir_cycle_req", 64'(mem_req), 64'd0);
    adv();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (i == 0) chk("redir_next_vld", 64'(inst_valid), 64'd0);
      a = first_pc[AW-1:0] + AW'(i);
      chk("redir_addr", 64'(mem_addr), 64'(a));
      adv();
    end
    drain(40);
    chk("redir_latency", 64'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 64'(t + 6));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) imem[i] = 8'h00;
    put_word(0,  32'h014b4820);
    put_word(4,  32'h02538822);
    put_word(8,  32'h8d49ff9c);
    put_word(12, 32'had4a0064);
    put_word(16, 32'h112a0001);
    put_word(20, 32'h154d0000);
    put_word(32'hffc, 32'hdeadbeef);
    mem_rdata = 8'h00;
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b1;

    // Reset values
    adv();
    smp();
    chk("rst_vld",  64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_pc",   64'(inst_pc), 64'd0);
    chk("rst_req",  64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    adv();
    rst = 1'b1;
    cyc_n = 0;
    acc_cyc.delete();

    // Streaming six words with the consumer always ready
    exp_q.push_back({32'd0,  32'h014b4820});
    exp_q.push_back({32'd4,  32'h02538822});
    exp_q.push_back({32'd8,  32'h8d49ff9c});
    exp_q.push_back({32'd12, 32'had4a0064});
    exp_q.push_back({32'd16, 32'h112a0001});
    exp_q.push_back({32'd20, 32'h154d0000});
    for (int c = 0; c < 24; c++) begin
      smp();
      chk("stream_req", 64'(mem_req), 64'd1);
      chk("stream_addr", 64'(mem_addr), 64'(c));
      if (c == 4) chk("stream_vld_c4", 64'(inst_valid), 64'd0);
      adv();
    end
    drain(20);
    for (int i = 0; i < 6; i++)
      chk("stream_accept_cyc", 64'(acc_cyc.size() > i ? acc_cyc[i] : -1), 64'(5 + 4 * i));

    // Redirect mid-word with a non-empty FIFO and a same-cycle pop request
    while (cyc_n < 29) begin
      smp();
      adv();
    end
    smp();
    chk("redir_pre_vld", 64'(inst_valid), 64'd1);
    adv();
    exp_q.push_back({32'h14, 32'h154d0000});
    redir(32'h14, 32'h14);

    // Unaligned target is forced to word alignment
    exp_q.push_back({32'h10, 32'h112a0001});
    redir(32'h13, 32'h10);

    // Address wrap: memory address wraps, inst_pc does not
    exp_q.push_back({32'hffc,  32'hdeadbeef});
    exp_q.push_back({32'h1000, 32'h014b4820});
    redir(32'hffc, 32'hffc);

    // Backpressure from reset: FIFO fills, then one pop admits exactly one more word
    inst_ready = 1'b0;
    do_reset();
    exp_q.push_back({32'd0,  32'h014b4820});
    exp_q.push_back({32'd4,  32'h02538822});
    exp_q.push_back({32'd8,  32'h8d49ff9c});
    exp_q.push_back({32'd12, 32'had4a0064});
    exp_q.push_back({32'd16, 32'h112a0001});
    for (int c = 0; c < 20; c++) begin
      smp();
      if (c >= 16) chk("full_wait_req", 64'(mem_req), 64'd0);
      if (c == 19) chk("full_head", {inst_pc, 31'd0, inst_valid}, {32'd0, 32'd1});
      adv();
    end
    inst_ready = 1'b1;
    smp();
    adv();
    inst_ready = 1'b0;
    for (int c = 21; c < 30; c++) begin
      smp();
      if (c == 21) chk("refill_req", {31'd0, mem_req, 20'd0, mem_addr}, {32'd1, 32'd16});
      if (c >= 25) chk("refill_one_word", 64'(mem_req), 64'd0);
      adv();
    end
    inst_ready = 1'b1;
    drain(20);
    chk("full_pop_cyc",  64'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 64'd20);
    chk("full_drain_cyc", 64'(acc_cyc.size() > 1 ? acc_cyc[1] : -1), 64'd30);

    // Reset pulse mid-word with a non-empty FIFO
    while (cyc_n < 38) begin
      smp();
      adv();
    end
    smp();
    chk("midrst_pre_vld", 64'(inst_valid), 64'd1);
    adv();
    do_reset();
    exp_q.push_back({32'd0, 32'h014b4820});
    inst_ready = 1'b1;
    smp();
    chk("midrst_vld",  64'(inst_valid), 64'd0);
    chk("midrst_inst", 64'(inst), 64'd0);
    chk("midrst_pc",   64'(inst_pc), 64'd0);
    chk("midrst_req",  {31'd0, mem_req, 20'd0, mem_addr}, {32'd1, 32'd0});
    adv();
    drain(20);
    chk("midrst_latency", 64'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch front-end for the `mips` core. It reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit instruction words. Each word is buffered with its PC in a small prefetch FIFO and handed downstream over a valid/ready handshake. A branch redirect from the execute stage flushes the FIFO and any in-progress or in-flight fetch, then restarts fetch at the target.

## Interface
Parameters:
- ADDR_W, 12, instruction memory byte-address width (4096 bytes)
- DEPTH, 4, prefetch FIFO depth in words (power of two, >= 2)
- RESET_PC, 32'h0, fetch PC after reset (word aligned)

Ports:
- clk  in  1  single clock, all logic on the rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets)
- mem_req  out  1  byte read request this cycle
- mem_addr  out  ADDR_W  byte address of the request
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_req
- redirect  in  1  one-cycle pulse: discard everything, refetch at redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] are ignored (forced to 0)
- inst_valid  out  1  inst/inst_pc hold a valid word
- inst_ready  in  1  consumer accepts the word this cycle
- inst  out  32  instruction word, {byte@pc, @pc+1, @pc+2, @pc+3}
- inst_pc  out  32  byte address of inst

## Operation
- fetch_pc is 32 bits and word aligned. Byte index k (0..3) increments each cycle a request is issued.
- Request address: mem_addr = fetch_pc[ADDR_W-1:0] + k, truncated to ADDR_W bits, so it wraps at 2^ADDR_W. inst_pc carries the full 32-bit fetch_pc with no wrap.
- Fetch FSM:
  - FETCH: issue byte k.
    - After k=3 issues, fetch_pc += 4 and k returns to 0.
    - If a word may not be started, go to WAIT.
  - WAIT: mem_req=0. Return to FETCH when a word may be started.
- Starting a word (issuing k=0) requires: occupancy + words in progress < DEPTH.
  - Words in progress means a word with bytes issued but not yet pushed.
  - A pop in the same cycle counts as freeing a slot.
- Assembly:
  - The returning byte shifts into a 32-bit register (first byte ends in [31:24]).
  - When byte 3 returns, push {word, pc} into the FIFO.
- FIFO: in-order circular buffer with a pointer plus count.
  - The head is presented on inst/inst_pc.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle are both allowed, including when full or empty (count unchanged).
- Redirect (cycle t), all taking effect at the edge ending cycle t:
  - FIFO is emptied.
  - Any pop requested in cycle t is dropped; the consumer treats redirect as overriding.
  - The partially assembled word is discarded.
  - The byte returning in cycle t (from a request at t-1) is discarded.
  - mem_req=0 in cycle t.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}, k <= 0, FSM <= FETCH.
- Reset overrides redirect and all other inputs.

## Timing
- Reset values (edge with rst==0):
  - Outputs: mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0.
  - Internal: fetch_pc=RESET_PC, k=0, FIFO empty, FSM=FETCH, assembly register cleared, no byte outstanding.
- Cycle 0 is the first cycle with rst==1: mem_req=1, mem_addr=RESET_PC[ADDR_W-1:0].
- Word latency:
  - Byte k requested in cycle c+k, data in cycle c+k+1.
  - Push at the edge ending cycle c+4.
  - inst_valid=1 in cycle c+5, so the first word is visible in cycle 5.
- Throughput: back-to-back requests with no bubbles give one word per 4 cycles while not blocked.
- After redirect in cycle t:
  - inst_valid=0 in cycle t+1.
  - First request to the target in cycle t+1.
  - First new word valid in cycle t+6.
- Handshake:
  - inst and inst_pc are stable while inst_valid && !inst_ready.
  - inst_valid never drops without a pop, redirect or reset.
- Full: at most DEPTH words are ever buffered or in progress. The FIFO never overflows, and no byte is lost or duplicated.
- Empty: inst_valid=0 and inst/inst_pc hold their last value.
- Reset asserted mid-word: the next edge applies reset values. Any in-flight byte is ignored.

## Test plan
- Reset release; memory bytes 0..3 = 01 4b 48 20, inst_ready=1 -> mem_addr 0,1,2,3 in cycles 0..3; inst_valid first high in cycle 5 with inst=0x014b4820, inst_pc=0.
- Six-word program loaded at 0..23 (0x014b4820, 0x02538822, 0x8d49ff9c, 0xad4a0064, 0x112a0001, 0x154d0000), inst_ready=1 -> words accepted in order, inst_pc 0,4,...,20, one word every 4 cycles, mem_req continuous.
- inst_ready=0 from reset -> after 4 words, mem_req=0 (WAIT) and the FIFO holds 0..12. Raise inst_ready for 1 cycle -> exactly one pop, then exactly one new word (pc 16) is fetched. Full drain yields 0,4,8,12,16 with no gaps or duplicates.
- redirect=1, redirect_pc=0x14 while a word is half-assembled and the FIFO is non-empty, inst_ready=1 in the same cycle:
  - inst_valid=0 next cycle, and the dropped pop is not delivered.
  - mem_req=0 in the redirect cycle.
  - inst=0x154d0000, inst_pc=0x14 valid at t+6.
- redirect_pc=0x13 -> fetch restarts at 0x10.
- Wrap: ADDR_W=12, redirect to 0xFFC -> mem_addr 0xFFC..0xFFF then 0x000; inst_pc 0xFFC then 0x1000.
- rst=0 for one cycle mid-word with a non-empty FIFO -> all outputs take reset values next cycle; fetch restarts at RESET_PC and the first word is valid 5 cycles after release.
